// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: op codes, FSM states and code-group constants shared by the execute unit
package seq_alu_pkg;
    typedef enum logic [4:0] {
        OP_ADD    = 5'b00000,
        OP_SUB    = 5'b00001,
        OP_OR     = 5'b00010,
        OP_AND    = 5'b00011,
        OP_XOR    = 5'b00100,
        OP_SRA    = 5'b00101,
        OP_SRL    = 5'b00110,
        OP_SLL    = 5'b00111,
        OP_SLT    = 5'b01101,
        OP_SLTU   = 5'b01110,
        OP_MUL    = 5'b10000,
        OP_MULH   = 5'b10001,
        OP_MULHSU = 5'b10010,
        OP_MULHU  = 5'b10011,
        OP_DIV    = 5'b10100,
        OP_DIVU   = 5'b10101,
        OP_REM    = 5'b10110,
        OP_REMU   = 5'b10111
    } op_t;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    localparam logic [1:0] M_GRP = 2'b10;
    localparam int DIV_BIT = 2;
endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: request/result bundle between the EX stage and the execute unit
interface seq_alu_if #(
    parameter int XLEN = 32
);
    logic            i_valid;
    logic [4:0]      i_ctrl;
    logic [XLEN-1:0] i_1;
    logic [XLEN-1:0] i_2;
    logic            i_kill;
    logic            o_ready;
    logic            o_valid;
    logic [XLEN-1:0] o_1;
    logic            o_zero;
    logic            o_neg;
    logic            o_negU;
    logic            o_illegal;
    modport master (
        output i_valid, i_ctrl, i_1, i_2, i_kill,
        input  o_ready, o_valid, o_1, o_zero, o_neg, o_negU, o_illegal
    );
    modport slave (
        input  i_valid, i_ctrl, i_1, i_2, i_kill,
        output o_ready, o_valid, o_1, o_zero, o_neg, o_negU, o_illegal
    );
endinterface

// File: rtl/seq_alu_mdu.sv
// seq_alu_mdu: iterative shift-add multiplier / restoring divider on magnitudes (used under SEQ_ALU_MDU_EN)
module seq_alu_mdu
    import seq_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            run,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            fast,
    output logic            last,
    output logic [XLEN-1:0] fast_res,
    output logic [XLEN-1:0] res
);
    localparam int CW = $clog2(XLEN);
    logic              sa, sb, an, bn, ge, neg_q;
    logic [2:0]        op_q;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   ma, mb, m_q, dif, v;
    logic [XLEN:0]     sum, rs;
    logic [2*XLEN-1:0] acc, acc_nxt, prod;
    assign sa = op[DIV_BIT] ? ~op[0] : op[1] ^ op[0];
    assign sb = op[DIV_BIT] ? ~op[0] : op[1:0] == 2'b01;
    assign an = sa & a[XLEN-1];
    assign bn = sb & b[XLEN-1];
    assign ma = an ? -a : a;
    assign mb = bn ? -b : b;
    assign fast = op[DIV_BIT] & ((b == '0) | (~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (&b)));
    assign fast_res = (b == '0) ? (op[1] ? a : '1) : (op[1] ? '0 : a);
    assign sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m_q} : '0);
    assign rs = acc[2*XLEN-1:XLEN-1];
    assign ge = rs >= {1'b0, m_q};
    assign dif = rs[XLEN-1:0] - m_q;
    assign acc_nxt = op_q[DIV_BIT] ? (ge ? {dif, acc[XLEN-2:0], 1'b1} : {rs[XLEN-1:0], acc[XLEN-2:0], 1'b0})
                                   : {sum, acc[XLEN-1:1]};
    assign prod = neg_q ? -acc_nxt : acc_nxt;
    assign v = op_q[1] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
    assign res = op_q[DIV_BIT] ? (neg_q ? -v : v) : (op_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    assign last = run & (cnt == CW'(XLEN - 1));
    // load magnitudes and the result sign on start, then advance one bit per running cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            m_q   <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
            cnt   <= '0;
        end else if (start) begin
            acc   <= {{XLEN{1'b0}}, op[DIV_BIT] ? ma : mb};
            m_q   <= op[DIV_BIT] ? mb : ma;
            op_q  <= op;
            neg_q <= (op[DIV_BIT] & op[1]) ? an : an ^ bn;
            cnt   <= '0;
        end else if (run) begin
            acc   <= acc_nxt;
            cnt   <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked XLEN-bit execute unit with registered result; SEQ_ALU_MDU_EN adds iterative mul/div
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic      i_clk,
    input logic      i_rst_n,
    seq_alu_if.slave io
);
    localparam int SW = $clog2(XLEN);
    state_t          state, nxt;
    logic            accept, start, last, legal, lt, lt_q;
    logic [XLEN-1:0] a, b, res, mdu_res, wr;
    logic [SW-1:0]   sh;
    assign a = io.i_1;
    assign b = io.i_2;
    assign sh = b[SW-1:0];
    assign lt = a < b;
    assign io.o_valid = state == S_DONE;
    assign accept = io.i_valid & io.o_ready & ~io.i_kill;
    assign wr = last ? mdu_res : res;
`ifdef SEQ_ALU_MDU_EN
    logic            fast;
    logic [XLEN-1:0] fast_res;
    assign io.o_ready = (state == S_IDLE) | (state == S_DONE);
    assign start = accept & (io.i_ctrl[4:3] == M_GRP) & ~fast;
    seq_alu_mdu #(.XLEN(XLEN)) u_mdu (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .start   (start),
        .run     ((state == S_MUL) | (state == S_DIV)),
        .op      (io.i_ctrl[2:0]),
        .a       (a),
        .b       (b),
        .fast    (fast),
        .last    (last),
        .fast_res(fast_res),
        .res     (mdu_res)
    );
    // remember the unsigned compare of the accepted operands for multi-cycle results
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) lt_q <= 1'b0;
        else if (accept) lt_q <= lt;
    end
`else
    assign io.o_ready = 1'b1;
    assign start = 1'b0;
    assign last = 1'b0;
    assign mdu_res = '0;
    assign lt_q = 1'b0;
`endif
    // single-cycle result; undefined or compiled-out codes give zero and clear legal
    always_comb begin
        res = '0;
        legal = 1'b1;
        case (io.i_ctrl)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_OR:   res = a | b;
            OP_AND:  res = a & b;
            OP_XOR:  res = a ^ b;
            OP_SRA:  res = $signed(a) >>> sh;
            OP_SRL:  res = a >> sh;
            OP_SLL:  res = a << sh;
            OP_SLT:  res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: res = {{(XLEN-1){1'b0}}, lt};
`ifdef SEQ_ALU_MDU_EN
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: res = fast_res;
`endif
            default: legal = 1'b0;
        endcase
    end
    // next state: kill wins, then accept, then DONE retires, then iteration end
    always_comb begin
        nxt = state;
        if (io.i_kill) nxt = S_IDLE;
        else if (accept) nxt = start ? (io.i_ctrl[DIV_BIT] ? S_DIV : S_MUL) : S_DONE;
        else if (state == S_DONE) nxt = S_IDLE;
        else if (last) nxt = S_DONE;
    end
    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else state <= nxt;
    end
    // result and flags are written together; a kill leaves them untouched
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            io.o_1       <= '0;
            io.o_zero    <= 1'b0;
            io.o_neg     <= 1'b0;
            io.o_negU    <= 1'b0;
            io.o_illegal <= 1'b0;
        end else if (!io.i_kill && ((accept && !start) || last)) begin
            io.o_1       <= wr;
            io.o_zero    <= wr == '0;
            io.o_neg     <= wr[XLEN-1];
            io.o_negU    <= last ? lt_q : lt;
            io.o_illegal <= ~last & ~legal;
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized scoreboard bench for seq_alu (XLEN=32, either SEQ_ALU_MDU_EN build)
module tb_seq_alu;
    localparam int XLEN = 32;
    typedef struct {
        logic [31:0] res;
        logic        zero, neg, negu, ill;
        int          cyc;
    } exp_t;
    typedef struct {
        logic [4:0]  c;
        logic [31:0] a, b;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] held = '0;
    exp_t q[$];

    seq_alu_if #(.XLEN(XLEN)) io ();
    seq_alu #(.XLEN(XLEN)) dut (.i_clk(clk), .i_rst_n(rst_n), .io(io));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic exp_t model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [63:0] p;
        logic [31:0] r;
        logic ill, ovf;
        int lat;
        r = '0;
        p = '0;
        ill = 1'b0;
        lat = 1;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (c)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a | b;
            5'd3:  r = a & b;
            5'd4:  r = a ^ b;
            5'd5:  r = $signed(a) >>> b[4:0];
            5'd6:  r = a >> b[4:0];
            5'd7:  r = a << b[4:0];
            5'd13: r = {31'b0, $signed(a) < $signed(b)};
            5'd14: r = {31'b0, a < b};
`ifdef SEQ_ALU_MDU_EN
            5'd16: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; lat = XLEN + 1; end
            5'd17: begin p = longint'($signed(a)) * longint'($signed(b)); r = p[63:32]; lat = XLEN + 1; end
            5'd18: begin p = longint'($signed(a)) * longint'({32'b0, b}); r = p[63:32]; lat = XLEN + 1; end
            5'd19: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; lat = XLEN + 1; end
            5'd20: begin
                if (b == 0) r = '1;
                else if (ovf) r = a;
                else begin r = $signed(a) / $signed(b); lat = XLEN + 1; end
            end
            5'd21: begin
                if (b == 0) r = '1;
                else begin r = a / b; lat = XLEN + 1; end
            end
            5'd22: begin
                if (b == 0) r = a;
                else if (ovf) r = '0;
                else begin r = $signed(a) % $signed(b); lat = XLEN + 1; end
            end
            5'd23: begin
                if (b == 0) r = a;
                else begin r = a % b; lat = XLEN + 1; end
            end
`endif
            default: ill = 1'b1;
        endcase
        e.res = r;
        e.zero = r == 0;
        e.neg = r[31];
        e.negu = a < b;
        e.ill = ill;
        e.cyc = lat;
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!io.o_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!io.o_ready) chk("ready_timeout", 64'(io.o_ready), 64'd1);
        io.i_valid = 1'b1;
        io.i_ctrl = c;
        io.i_1 = a;
        io.i_2 = b;
        e = model(c, a, b);
        e.cyc = e.cyc + cyc;
        q.push_back(e);
        @(posedge clk);
        #1;
        io.i_valid = 1'b0;
        io.i_ctrl = 5'($urandom);
        io.i_1 = $urandom;
        io.i_2 = $urandom;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_o_1"}, 64'(io.o_1), 64'd0);
        chk({tag, "_flags"}, 64'({io.o_valid, io.o_zero, io.o_neg, io.o_negU, io.o_illegal}), 64'd0);
        chk({tag, "_ready"}, 64'(io.o_ready), 64'd1);
    endtask

    vec_t dirs[] = '{
        '{5'b00001, 32'd5, 32'd7},
        '{5'b00101, 32'h8000_0000, 32'h24},
        '{5'b00111, 32'h1234_5678, 32'h21},
        '{5'b10001, 32'h8000_0000, 32'h8000_0000},
        '{5'b10000, 32'h8000_0000, 32'h8000_0000},
        '{5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{5'b10100, 32'hFFFF_FFF9, 32'd2},
        '{5'b10110, 32'hFFFF_FFF9, 32'd2},
        '{5'b10100, 32'h8000_0000, 32'hFFFF_FFFF},
        '{5'b10101, 32'd7, 32'd0},
        '{5'b10111, 32'd7, 32'd0},
        '{5'b01000, 32'd3, 32'd4},
        '{5'b01101, 32'hFFFF_FFFF, 32'd1},
        '{5'b01110, 32'hFFFF_FFFF, 32'd1},
        '{5'b10010, 32'hFFFF_FFFF, 32'd2},
        '{5'b10110, 32'h8000_0000, 32'hFFFF_FFFF},
        '{5'b00000, 32'hFFFF_FFFF, 32'd1}
    };

    initial begin
        io.i_valid = 1'b0;
        io.i_kill = 1'b0;
        io.i_ctrl = '0;
        io.i_1 = '0;
        io.i_2 = '0;
        fork
            begin
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (rst_n && io.o_valid) begin
                        if (q.size() == 0) chk("unexpected_valid", 64'(io.o_valid), 64'd0);
                        else begin
                            e = q.pop_front();
                            held = e.res;
                            chk("o_1", 64'(io.o_1), 64'(e.res));
                            chk("flags_zero_neg_negU_illegal", 64'({io.o_zero, io.o_neg, io.o_negU, io.o_illegal}),
                                64'({e.zero, e.neg, e.negu, e.ill}));
                            chk("valid_cycle", 64'(cyc), 64'(e.cyc));
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        foreach (dirs[i]) issue(dirs[i].c, dirs[i].a, dirs[i].b);

        for (int i = 0; i < 300; i++) begin
            logic [4:0] c;
            c = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(16, 23)) : 5'($urandom_range(0, 31));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(c, pick(), pick());
        end

        for (int n = 0; n < 100 && q.size() != 0; n++) @(negedge clk);
        chk("drain", 64'(q.size()), 64'd0);

        @(negedge clk);
        io.i_valid = 1'b1;
        io.i_kill = 1'b1;
        io.i_ctrl = 5'b00000;
        io.i_1 = 32'd1;
        io.i_2 = 32'd1;
        @(posedge clk);
        #1;
        io.i_valid = 1'b0;
        io.i_kill = 1'b0;
        @(negedge clk);
        chk("kill_blocks_accept_valid", 64'(io.o_valid), 64'd0);
        chk("kill_blocks_accept_o_1", 64'(io.o_1), 64'(held));

        issue(5'b10101, 32'd100, 32'd3);
        repeat (10) @(negedge clk);
        io.i_kill = 1'b1;
        @(posedge clk);
        #1;
        io.i_kill = 1'b0;
        @(negedge clk);
        chk("kill_ready", 64'(io.o_ready), 64'd1);
        chk("kill_valid", 64'(io.o_valid), 64'd0);
        chk("kill_o_1_held", 64'(io.o_1), 64'(held));
        q.delete();
        repeat (40) @(negedge clk);

        issue(5'b00001, 32'd1, 32'd9);
        issue(5'b10101, 32'd100, 32'd3);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_state("midop_reset");
        q.delete();
        held = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        issue(5'b00010, 32'h0F0F_0000, 32'h0000_F0F0);
        for (int n = 0; n < 100 && q.size() != 0; n++) @(negedge clk);
        chk("final_drain", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked integer execute unit: the successor to the single-cycle combinational ALU. It keeps that ALU's operation codes and its zero/neg/negU flags. It adds a configurable datapath width, masked shift amounts, an illegal-op flag, a kill input, and an optional iterative multiply/divide unit (RV32M/RV64M semantics). It sits in the EX stage, between operand forwarding and writeback, and results are registered.

## Interface
- XLEN, 32: datapath width; must be 32 or 64.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_valid  in  1  operation request; accepted when i_valid & o_ready.
- i_ctrl  in  5  operation code (see Operation).
- i_1, i_2  in  XLEN  operands.
- i_kill  in  1  synchronous abort of any in-flight operation.
- o_ready  out  1  unit can accept an operation this cycle.
- o_valid  out  1  one-cycle pulse; result and flags are valid.
- o_1  out  XLEN  result, registered, held until the next result.
- o_zero  out  1  o_1 == 0.
- o_neg  out  1  o_1[XLEN-1].
- o_negU  out  1  unsigned i_1 < i_2, computed on the accepted operands.
- o_illegal  out  1  accepted code undefined or compiled out; o_1 = 0.

## Operation
- Base codes, 1-cycle:
  - 00000 add, 00001 sub, 00010 or, 00011 and, 00100 xor.
  - 00101 sra, 00110 srl, 00111 sll.
  - 01101 slt, 01110 sltu.
- Shift amount = i_2[$clog2(XLEN)-1:0]; upper bits ignored.
- M codes:
  - 10000 mul: low XLEN bits of the product.
  - 10001 mulh (s×s), 10010 mulhsu (s×u), 10011 mulhu (u×u): high XLEN bits.
  - 10100 div, 10101 divu, 10110 rem, 10111 remu.
- All other codes are illegal: o_illegal=1, o_1=0, 1-cycle.
- FSM states IDLE, MUL, DIV, DONE.
  - IDLE/DONE + accept of a base, illegal or fast-path code → DONE.
  - IDLE/DONE + accept of mul* → MUL.
  - IDLE/DONE + accept of div*/rem* → DIV.
  - DONE without accept → IDLE.
  - MUL/DIV: count XLEN iterations, then → DONE.
- o_ready = (state == IDLE) | (state == DONE), giving back-to-back issue. o_ready = 0 in MUL and DIV.
- o_valid = (state == DONE).
- Multiply: shift-add, one bit per cycle, on operand magnitudes; sign fixed in the final iteration write. 2·XLEN-bit accumulator.
- Divide: restoring, one quotient bit per cycle on magnitudes. Quotient sign = sign(i_1) ^ sign(i_2); remainder sign = sign(i_1).
- Divide fast paths, resolved in 1 cycle, no DIV state:
  - Divisor 0: div/divu → all ones; rem/remu → i_1.
  - Signed overflow (most-negative / −1): div → i_1; rem → 0.
- Flags are computed from the final o_1 and latched operands, and registered together with o_1.
- i_kill: any state → IDLE next cycle, no o_valid. Outputs o_1 and flags keep their previous values. An i_valid in the same cycle as i_kill is not accepted.
- Reset (any time, including mid-iteration):
  - state IDLE, o_ready=1, o_valid=0.
  - o_1=0, o_zero=0, o_neg=0, o_negU=0, o_illegal=0.
  - In-flight operation lost.

## Timing
- Accept at cycle N:
  - base/illegal/fast-path: o_valid at N+1.
  - mul*/div*/rem*: o_valid at N+XLEN+1.
- Operands and i_ctrl are sampled only at accept; later changes are ignored.
- A new accept in the DONE cycle produces the next o_valid at the earliest N+2 relative to the prior accept.
- No combinational path from inputs to outputs except i_kill-independent o_ready (a function of state only).

## Configuration
- SEQ_ALU_MDU_EN defined: M codes implemented as above; MUL/DIV states and iteration counter present.
- Not defined: M codes are illegal (o_illegal=1, o_1=0, 1-cycle). No multiplier/divider logic, no MUL/DIV states, and o_ready is always 1.

## Structure
- seq_alu_pkg holds:
  - the op-code enum (5-bit);
  - the FSM state enum;
  - localparams for the code groups (M-op bit = i_ctrl[4]).
- Sub-module seq_alu_mdu: iterative multiply/divide datapath. Start/done handshake, XLEN parameter, fast-path detection. Instantiated only under SEQ_ALU_MDU_EN.

## Test plan
- sub, i_1=5, i_2=7 → o_1=0xFFFFFFFE, o_neg=1, o_negU=1, o_zero=0, o_valid at N+1.
- sra, i_1=0x80000000, i_2=0x24 (shamt 4) → 0xF8000000. sll by 0x21 → i_1<<1.
- mulh, 0x80000000 × 0x80000000 → 0x40000000 at N+33; mul → 0. mulhu 0xFFFFFFFF² → 0xFFFFFFFE.
- div −7/2 → 0xFFFFFFFD; rem −7/2 → 0xFFFFFFFF.
- Fast paths, o_valid at N+1:
  - div 0x80000000/0xFFFFFFFF → 0x80000000.
  - divu 7/0 → 0xFFFFFFFF.
  - remu 7/0 → 7.
- divu 100/3 with i_kill at N+10 → no o_valid, o_ready=1 at N+11, o_1 unchanged. Repeat with i_rst_n low at N+10 → all outputs 0. Code 01000 → o_illegal=1, o_1=0.
